// File: rtl/myalu_pkg.sv
// Shared types and constants for the myalu AXI4-Lite slave: ALU opcodes,
// FSM state types, register word indices, response codes and status bit positions.
package myalu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_SLL    = 3'd5,
    ALU_SRL    = 3'd6,
    ALU_PASS_A = 3'd7
  } alu_op_e;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  // Snapshot of both channel FSMs for checkers bound onto the slave.
  typedef struct packed {
    wr_state_e w_state;
    rd_state_e r_state;
    logic      aw_held;
    logic      w_held;
  } myalu_dbg_t;

  // Word indices (byte address bits [4:2]).
  localparam logic [2:0] REG_OP_A    = 3'd0;
  localparam logic [2:0] REG_OP_B    = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_SCRATCH = 3'd3;
  localparam logic [2:0] REG_RESULT  = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_ZERO_BIT  = 0;
  localparam int STATUS_CARRY_BIT = 1;
  localparam int STATUS_DONE_BIT  = 2;
  localparam int STATUS_COUNT_LSB = 16;

  // CTRL keeps only opcode [2:0] and irq_en [8].
  localparam logic [31:0] CTRL_MASK = 32'h0000_0107;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/myalu_core.sv
// Registered ALU: when start is high, result/zero/carry are captured from
// op, a and b on that clock edge; otherwise they hold.
module myalu_core
  import myalu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] f_res;
  logic        f_carry;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    f_res   = a;
    f_carry = 1'b0;
    case (op)
      ALU_ADD:    begin f_res = sum[31:0];  f_carry = sum[32];  end
      // diff[32] is the borrow, set exactly when a < b.
      ALU_SUB:    begin f_res = diff[31:0]; f_carry = diff[32]; end
      ALU_AND:    f_res = a & b;
      ALU_OR:     f_res = a | b;
      ALU_XOR:    f_res = a ^ b;
      ALU_SLL:    f_res = a << b[4:0];
      ALU_SRL:    f_res = a >> b[4:0];
      ALU_PASS_A: f_res = a;
      default:    f_res = a;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else if (start) begin
      result <= f_res;
      zero   <= (f_res == 32'd0);
      carry  <= f_carry;
    end
  end

endmodule

// File: rtl/myalu_axil_slave.sv
// AXI4-Lite register slave for the myalu IP: OP_A/OP_B/CTRL/SCRATCH RW, RESULT/STATUS RO.
// Define MYALU_IRQ_EN to add the registered irq output (CTRL[8] & done).
module myalu_axil_slave
  import myalu_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
`ifdef MYALU_IRQ_EN
  ,
  output logic                            irq
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // The slave never retracts rvalid/bvalid or their payload until the matching ready.
  // Readies are held low while reset is asserted.

  wr_state_e   w_state, w_state_next;
  rd_state_e   r_state, r_state_next;
  logic        aw_held, w_held;
  logic [2:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, ar_hs, do_write;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] wr_data, rd_mux, rdata_q;
  logic [3:0]  wr_strb;
  logic [1:0]  bresp_q, rresp_q, rd_resp;
  logic [31:0] op_a, op_b, ctrl, scratch, result;
  logic        zero, carry, done, alu_start;
  logic [15:0] op_count;
  alu_op_e     alu_op;
  myalu_dbg_t  dbg;
  logic        unused_ok;

  // Write channel: AW and W are accepted independently, the register is
  // updated on the edge where both are available.
  always_comb begin
    w_state_next  = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    do_write      = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = !reset && !aw_held;
        s_axi_wready  = !reset && !w_held;
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          do_write     = 1'b1;
          w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign wr_idx  = aw_held ? aw_idx_q : s_axi_awaddr[4:2];
  assign wr_data = w_held ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      w_state <= w_state_next;
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= (wr_idx <= REG_SCRATCH) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axi_awaddr[4:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
      end
    end
  end

  assign s_axi_bresp = bresp_q;

  // Read channel.
  always_comb begin
    r_state_next  = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ar_hs         = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = !reset;
        ar_hs         = s_axi_arvalid && s_axi_arready;
        if (ar_hs) r_state_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_idx  = s_axi_araddr[4:2];
    rd_mux  = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      REG_OP_A:    rd_mux = op_a;
      REG_OP_B:    rd_mux = op_b;
      REG_CTRL:    rd_mux = ctrl;
      REG_SCRATCH: rd_mux = scratch;
      REG_RESULT:  rd_mux = result;
      REG_STATUS: begin
        rd_mux[STATUS_ZERO_BIT]           = zero;
        rd_mux[STATUS_CARRY_BIT]          = carry;
        rd_mux[STATUS_DONE_BIT]           = done;
        rd_mux[STATUS_COUNT_LSB +: 16]    = op_count;
      end
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_state_next;
      if (ar_hs) begin
        rdata_q <= rd_mux;
        rresp_q <= rd_resp;
      end
    end
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  // Register file and ALU bookkeeping; a fresh op outranks a RESULT-read clear of done.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      ctrl      <= '0;
      scratch   <= '0;
      alu_start <= 1'b0;
      done      <= 1'b0;
      op_count  <= '0;
    end else begin
      alu_start <= do_write && (wr_idx <= REG_CTRL);
      if (do_write) begin
        case (wr_idx)
          REG_OP_A:    op_a    <= apply_wstrb(op_a, wr_data, wr_strb);
          REG_OP_B:    op_b    <= apply_wstrb(op_b, wr_data, wr_strb);
          REG_CTRL:    ctrl    <= apply_wstrb(ctrl, wr_data, wr_strb) & CTRL_MASK;
          REG_SCRATCH: scratch <= apply_wstrb(scratch, wr_data, wr_strb);
          default:     ;
        endcase
      end
      if (alu_start) begin
        done     <= 1'b1;
        op_count <= op_count + 16'd1;
      end else if (ar_hs && (rd_idx == REG_RESULT)) begin
        done <= 1'b0;
      end
    end
  end

  assign alu_op = alu_op_e'(ctrl[2:0]);

  myalu_core u_core (
    .clock  (clock),
    .reset  (reset),
    .start  (alu_start),
    .op     (alu_op),
    .a      (op_a),
    .b      (op_b),
    .result (result),
    .zero   (zero),
    .carry  (carry)
  );

`ifdef MYALU_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) irq <= 1'b0;
    else       irq <= ctrl[8] & done;
  end
`endif

  assign dbg = '{w_state: w_state, r_state: r_state, aw_held: aw_held, w_held: w_held};

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0], dbg};

endmodule

// File: tb/tb_myalu_axil_slave.sv
// Self-checking bench for myalu_axil_slave: directed scenarios plus random
// AXI-Lite traffic scored against a register-level model of the slave.
module tb_myalu_axil_slave;
  import myalu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
`ifdef MYALU_IRQ_EN
  logic        irq;
`endif

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  myalu_axil_slave dut (
    .clock         (clock),
    .reset         (reset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
`ifdef MYALU_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];

  task automatic check(input string name, input logic [33:0] actual, input logic [33:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: no handshake within the cycle budget", name);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [4];
  logic [31:0] m_result;
  logic        m_zero, m_carry, m_done;
  logic [15:0] m_count;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
    m_result = 32'd0;
    m_zero   = 1'b0;
    m_carry  = 1'b0;
    m_done   = 1'b0;
    m_count  = 16'd0;
  endtask

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int          idx;
    logic [31:0] v, a, b;
    idx = int'(addr) / 4;
    if (idx > 3) begin
      resp = RESP_SLVERR;
      return;
    end
    resp = RESP_OKAY;
    v = m_reg[idx];
    for (int i = 0; i < 4; i++) if (strb[i]) v[8*i +: 8] = data[8*i +: 8];
    if (idx == 2) v = v & 32'h0000_0107;
    m_reg[idx] = v;
    if (idx == 3) return;
    a = m_reg[0];
    b = m_reg[1];
    m_carry = 1'b0;
    case (int'(m_reg[2] % 8))
      0: begin m_result = a + b; m_carry = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; end
      1: begin m_result = a - b; m_carry = (a < b); end
      2: m_result = a & b;
      3: m_result = a | b;
      4: m_result = a ^ b;
      5: m_result = a << (b % 32);
      6: m_result = a >> (b % 32);
      default: m_result = a;
    endcase
    m_zero  = (m_result == 32'd0);
    m_done  = 1'b1;
    m_count = m_count + 16'd1;
  endtask

  task automatic model_read(input logic [4:0] addr, output logic [33:0] exp);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 4)       exp = {RESP_OKAY, m_reg[idx]};
    else if (idx == 4) begin
      exp    = {RESP_OKAY, m_result};
      m_done = 1'b0;
    end else if (idx == 5)
      exp = {RESP_OKAY, m_count, 13'd0, m_done, m_carry, m_zero};
    else
      exp = {RESP_SLVERR, 32'd0};
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready  = 1'b0; s_axi_rready = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    model_reset();
    exp_b_q.delete();
    exp_r_q.delete();
  endtask

  task automatic send_aw(input logic [4:0] addr, input int delay);
    bit got = 1'b0;
    idle(delay);
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = s_axi_awready;
    end
    if (!got) timeout("aw_handshake");
    @(posedge clock); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
    bit got = 1'b0;
    idle(delay);
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    s_axi_wvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = s_axi_wready;
    end
    if (!got) timeout("w_handshake");
    @(posedge clock); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic recv_b(input int delay);
    bit got = 1'b0;
    idle(delay);
    s_axi_bready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = s_axi_bvalid;
    end
    if (!got) timeout("b_handshake");
    @(posedge clock); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic send_ar(input logic [4:0] addr);
    bit got = 1'b0;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = s_axi_arready;
    end
    if (!got) timeout("ar_handshake");
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic recv_r(input int delay);
    bit got = 1'b0;
    idle(delay);
    s_axi_rready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = s_axi_rvalid;
    end
    if (!got) timeout("r_handshake");
    @(posedge clock); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write_raw(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_d, input int w_d, input int b_d);
    fork
      send_aw(addr, aw_d);
      send_w(data, strb, w_d);
      recv_b(b_d);
    join
    idle(2);
  endtask

  task automatic axi_read_raw(input logic [4:0] addr, input int r_d);
    send_ar(addr);
    recv_r(r_d);
    idle(2);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_d, input int w_d, input int b_d);
    logic [1:0] resp;
    model_write(addr, data, strb, resp);
    exp_b_q.push_back(resp);
    axi_write_raw(addr, data, strb, aw_d, w_d, b_d);
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_d, input bit use_lit, input logic [33:0] lit);
    logic [33:0] exp;
    model_read(addr, exp);
    if (use_lit) check("model_read_pin", exp, lit);
    exp_r_q.push_back(exp);
    axi_read_raw(addr, r_d);
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic        prev_reset = 1'b1;
  logic        prev_bvalid = 1'b0, prev_bready = 1'b0;
  logic [1:0]  prev_bresp = 2'b00;
  logic        prev_rvalid = 1'b0, prev_rready = 1'b0;
  logic [33:0] prev_r = '0;

  always @(negedge clock) begin
    if (!reset) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_b: bresp 0x%0h with no write pending", s_axi_bresp);
        end else check("bresp", 34'(s_axi_bresp), 34'(exp_b_q.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_r: rdata 0x%0h with no read pending", s_axi_rdata);
        end else check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, exp_r_q.pop_front());
      end
      if (!prev_reset && prev_bvalid && !prev_bready)
        check("b_hold", {31'd0, s_axi_bvalid, s_axi_bresp}, {31'd0, 1'b1, prev_bresp});
      if (!prev_reset && prev_rvalid && !prev_rready)
        check("r_hold", {s_axi_rvalid ? 2'b00 : 2'b11, 32'd0} ^ {s_axi_rresp, s_axi_rdata}, prev_r);
    end
    prev_reset  <= reset;
    prev_bvalid <= s_axi_bvalid;
    prev_bready <= s_axi_bready;
    prev_bresp  <= s_axi_bresp;
    prev_rvalid <= s_axi_rvalid;
    prev_rready <= s_axi_rready;
    prev_r      <= {s_axi_rresp, s_axi_rdata};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp;
    logic [33:0] exp_a, exp_b2;
    logic [4:0]  addr;
    logic [31:0] data;

    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_awready", 34'(s_axi_awready), 34'd0);
    check("rst_wready",  34'(s_axi_wready),  34'd0);
    check("rst_arready", 34'(s_axi_arready), 34'd0);
    check("rst_bvalid",  34'(s_axi_bvalid),  34'd0);
    check("rst_rvalid",  34'(s_axi_rvalid),  34'd0);
    check("rst_bresp",   34'(s_axi_bresp),   34'd0);
    check("rst_rresp_rdata", {s_axi_rresp, s_axi_rdata}, 34'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_readies", 34'({s_axi_awready, s_axi_wready, s_axi_arready}), 34'b111);
    @(posedge clock); #1;

    // Basic write/readback; CTRL=3 selects OR, so RESULT = 1|2 = 3.
    axi_write(5'h00, 32'd1, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'd2, 4'hF, 0, 0, 0);
    axi_write(5'h08, 32'd3, 4'hF, 0, 0, 0);
    axi_write(5'h0C, 32'd4, 4'hF, 0, 0, 0);
    axi_read(5'h00, 0, 1, {RESP_OKAY, 32'd1});
    axi_read(5'h04, 1, 1, {RESP_OKAY, 32'd2});
    axi_read(5'h08, 0, 1, {RESP_OKAY, 32'd3});
    axi_read(5'h0C, 2, 1, {RESP_OKAY, 32'd4});
    axi_read(5'h10, 0, 1, {RESP_OKAY, 32'd3});

    // Overflowing add from a clean reset.
    do_reset();
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'd1, 4'hF, 0, 0, 0);
    axi_write(5'h08, 32'd0, 4'hF, 0, 0, 0);
    axi_read(5'h14, 0, 1, {RESP_OKAY, 32'h0003_0007});
    axi_read(5'h10, 0, 1, {RESP_OKAY, 32'd0});
    axi_read(5'h14, 0, 1, {RESP_OKAY, 32'h0003_0003});

    // RO and unmapped accesses.
    model_write(5'h10, 32'h1234, 4'hF, resp);
    check("model_ro_bresp", 34'(resp), 34'(RESP_SLVERR));
    exp_b_q.push_back(resp);
    axi_write_raw(5'h10, 32'h1234, 4'hF, 0, 0, 0);
    axi_write(5'h18, 32'h5678, 4'hF, 1, 0, 0);
    axi_read(5'h1C, 0, 1, {RESP_SLVERR, 32'd0});
    axi_read(5'h10, 0, 1, {RESP_OKAY, 32'd0});

    // AW three cycles ahead of W, bready held off; then a partial-strobe write.
    axi_write(5'h0C, 32'hDEAD_BEEF, 4'hF, 0, 3, 10);
    axi_read(5'h0C, 0, 1, {RESP_OKAY, 32'hDEAD_BEEF});
    axi_write(5'h0C, 32'h1122_3344, 4'b0101, 2, 0, 1);
    axi_read(5'h0C, 3, 1, {RESP_OKAY, 32'hDE22_BE44});
    axi_read(5'h14, 0, 1, {RESP_OKAY, 32'h0003_0003});

    // RESULT read in the same cycle as an OP_A write returns the old RESULT.
    model_read(5'h10, exp_a);
    check("model_same_cycle_pin", exp_a, {RESP_OKAY, 32'd0});
    exp_r_q.push_back(exp_a);
    model_write(5'h00, 32'd5, 4'hF, resp);
    exp_b_q.push_back(resp);
    fork
      axi_read_raw(5'h10, 0);
      axi_write_raw(5'h00, 32'd5, 4'hF, 0, 0, 0);
    join
    axi_read(5'h14, 0, 1, {RESP_OKAY, 32'h0004_0004});
    axi_read(5'h10, 0, 1, {RESP_OKAY, 32'd6});

    // Reset while a write response is pending.
    model_write(5'h04, 32'hA5A5_A5A5, 4'hF, resp);
    exp_b_q.push_back(resp);
    fork
      send_aw(5'h04, 0);
      send_w(32'hA5A5_A5A5, 4'hF, 0);
    join
    @(negedge clock);
    check("bvalid_pending", 34'(s_axi_bvalid), 34'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("bvalid_dropped", 34'(s_axi_bvalid), 34'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    exp_b_q.delete();
    exp_r_q.delete();
    idle(1);
    for (int i = 0; i < 6; i++) axi_read(5'(i * 4), 0, 1, {RESP_OKAY, 32'd0});

`ifdef MYALU_IRQ_EN
    axi_write(5'h08, 32'h100, 4'hF, 0, 0, 0);
    axi_write(5'h00, 32'd7, 4'hF, 0, 0, 0);
    @(negedge clock);
    check("irq_set", 34'(irq), 34'd1);
    @(posedge clock); #1;
    axi_read(5'h10, 0, 1, {RESP_OKAY, 32'd7});
    @(negedge clock);
    check("irq_clear", 34'(irq), 34'd0);
    @(posedge clock); #1;
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 120; n++) begin
      addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) < 70) addr[4:2] = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        if ($urandom_range(0, 3) == 0) data = data & 32'h0000_00FF;
        axi_write(addr, data, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        axi_read(addr, $urandom_range(0, 3), 0, 34'd0);
      end
    end
    model_read(5'h14, exp_b2);
    exp_r_q.push_back(exp_b2);
    axi_read_raw(5'h14, 0);

    idle(5);
    check("exp_b_drained", 34'(exp_b_q.size()), 34'd0);
    check("exp_r_drained", 34'(exp_r_q.size()), 34'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
